// File: rtl/sys_arr_pkg.sv
// sys_arr_pkg: shared array geometry defaults and the tile sequencer state type.
//   N  - array rows/cols (power of 2, >= 2)
//   DW - element width in bits
package sys_arr_pkg;
    localparam int N  = 4;
    localparam int DW = 8;
    typedef enum logic [1:0] {IDLE, LOAD_W, WAIT_SPACE, LOAD_IN} seq_state_t;
endpackage

// File: rtl/sys_arr_out_fifo.sv
// sys_arr_out_fifo: synchronous FIFO for drained array rows.
//   clk, rst        clock, synchronous active-high reset
//   push, push_data write request and word (dropped when full and not popping)
//   pop, pop_data   read request (ignored when empty) and head word
//   full, empty     occupancy flags
//   count           number of stored words
module sys_arr_out_fifo #(
    parameter int W = 8,
    parameter int DEPTH = 8,
    localparam int AW = DEPTH > 1 ? $clog2(DEPTH) : 1,
    localparam int CW = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push,
    input  logic [W-1:0]  push_data,
    input  logic          pop,
    output logic [W-1:0]  pop_data,
    output logic          full,
    output logic          empty,
    output logic [CW-1:0] count
);
    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wp, rp;
    logic          do_push, do_pop;

    assign full     = count == CW'(DEPTH);
    assign empty    = count == '0;
    assign do_pop   = pop & ~empty;
    // A pop frees the head slot in the same cycle, so a full FIFO can still accept.
    assign do_push  = push & (~full | do_pop);
    assign pop_data = mem[rp];

    always_ff @(posedge clk)
        if (do_push) mem[wp] <= push_data;

    always_ff @(posedge clk) begin
        if (rst) begin
            wp    <= '0;
            rp    <= '0;
            count <= '0;
        end else begin
            if (do_push) wp <= wp == AW'(DEPTH - 1) ? '0 : wp + 1'b1;
            if (do_pop) rp <= rp == AW'(DEPTH - 1) ? '0 : rp + 1'b1;
            count <= count + CW'(do_push) - CW'(do_pop);
        end
    end
endmodule

// File: rtl/sys_arr_tile_sequencer.sv
// sys_arr_tile_sequencer: sequences weight/input/partial-sum rows onto the systolic array and buffers results.
//   cmd_*       tile command handshake with reuse-weights and use-partials mode bits
//   wt_*/in_*/ps_* row stream handshakes
//   weight_en, input_en, partial_en, row_in_en, row_ps_en, array_in, array_in_partials: registered array drive
//   drained, fifo_has_space, out_en, row_out, array_output: array status and drained rows
//   res_*       result row stream out of the internal FIFO
//   busy        tile in progress, GEMM outstanding or results pending
//   err_overflow sticky: a drained row arrived with the FIFO full and no pop
module sys_arr_tile_sequencer #(
    parameter int N = sys_arr_pkg::N,
    parameter int DW = sys_arr_pkg::DW,
    parameter int OUT_DEPTH = 2 * N,
    parameter int MAX_GEMM = 4,
    localparam int RW = $clog2(N),
    localparam int CW = $clog2(OUT_DEPTH + 1),
    localparam int OW = $clog2(MAX_GEMM + 1)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            cmd_valid,
    output logic            cmd_ready,
    input  logic            cmd_reuse_w,
    input  logic            cmd_use_ps,
    input  logic            wt_valid,
    output logic            wt_ready,
    input  logic [DW*N-1:0] wt_data,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [DW*N-1:0] in_data,
    input  logic            ps_valid,
    output logic            ps_ready,
    input  logic [DW*N-1:0] ps_data,
    output logic            weight_en,
    output logic            input_en,
    output logic            partial_en,
    output logic [RW-1:0]   row_in_en,
    output logic [RW-1:0]   row_ps_en,
    output logic [DW*N-1:0] array_in,
    output logic [DW*N-1:0] array_in_partials,
    input  logic            drained,
    input  logic            fifo_has_space,
    input  logic            out_en,
    input  logic [RW-1:0]   row_out,
    input  logic [DW*N-1:0] array_output,
    output logic            res_valid,
    input  logic            res_ready,
    output logic [DW*N-1:0] res_data,
    output logic [RW-1:0]   res_row,
    output logic            res_last,
    output logic            busy,
    output logic            err_overflow
);
    import sys_arr_pkg::*;

    seq_state_t         state;
    logic [RW-1:0]      row;
    logic               use_ps;
    logic [OW-1:0]      outstanding;
    logic [CW-1:0]      credits;
    logic               full, empty;
    logic [CW-1:0]      fifo_count;
    logic [RW+DW*N-1:0] fifo_data;
    logic               beat_w, beat_in, last_row, advance, pop, cap, done_gemm;
    logic               unused_ok;

    assign last_row  = row == RW'(N - 1);
    assign cmd_ready = state == IDLE;
    assign wt_ready  = state == LOAD_W;
    assign beat_w    = wt_ready & wt_valid;
    assign beat_in   = (state == LOAD_IN) & in_valid & (~use_ps | ps_valid);
    assign in_ready  = beat_in;
    assign ps_ready  = beat_in & use_ps;
    // Result space is reserved per tile before inputs flow, so a drained tile always fits.
    assign advance   = (state == WAIT_SPACE) & fifo_has_space & (credits >= CW'(N))
                     & (outstanding < OW'(MAX_GEMM));
    assign res_valid = ~empty;
    assign pop       = res_ready & ~empty;
    assign cap       = out_en & (~full | pop);
    assign done_gemm = cap & (row_out == RW'(N - 1));
    assign res_data  = res_valid ? fifo_data[DW*N-1:0] : '0;
    assign res_row   = res_valid ? fifo_data[RW+DW*N-1 -: RW] : '0;
    assign res_last  = res_valid & (res_row == RW'(N - 1));
    assign busy      = (state != IDLE) | (outstanding != '0) | ~empty;
    // Array drain status is informational only; new tiles are never gated on it.
    assign unused_ok = ^{drained, fifo_count};

    sys_arr_out_fifo #(.W(RW + DW*N), .DEPTH(OUT_DEPTH)) u_fifo (
        .clk(clk),
        .rst(rst),
        .push(out_en),
        .push_data({row_out, array_output}),
        .pop(pop),
        .pop_data(fifo_data),
        .full(full),
        .empty(empty),
        .count(fifo_count)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state             <= IDLE;
            row               <= '0;
            use_ps            <= 1'b0;
            outstanding       <= '0;
            credits           <= CW'(OUT_DEPTH);
            err_overflow      <= 1'b0;
            weight_en         <= 1'b0;
            input_en          <= 1'b0;
            partial_en        <= 1'b0;
            row_in_en         <= '0;
            row_ps_en         <= '0;
            array_in          <= '0;
            array_in_partials <= '0;
        end else begin
            weight_en  <= beat_w;
            input_en   <= beat_in;
            partial_en <= beat_in & use_ps;
            if (beat_w | beat_in) begin
                row_in_en <= row;
                array_in  <= beat_w ? wt_data : in_data;
                row       <= row + 1'b1;
            end
            if (beat_in & use_ps) begin
                row_ps_en         <= row;
                array_in_partials <= ps_data;
            end
            outstanding <= outstanding + OW'(beat_in & last_row) - OW'(done_gemm);
            credits     <= credits - (advance ? CW'(N) : CW'(0)) + CW'(pop);
            if (out_en & full & ~pop) err_overflow <= 1'b1;
            case (state)
                IDLE: if (cmd_valid) begin
                    use_ps <= cmd_use_ps;
                    state  <= cmd_reuse_w ? WAIT_SPACE : LOAD_W;
                end
                LOAD_W:     if (beat_w & last_row) state <= WAIT_SPACE;
                WAIT_SPACE: if (advance) state <= LOAD_IN;
                LOAD_IN:    if (beat_in & last_row) state <= IDLE;
                default:    state <= IDLE;
            endcase
        end
    end
endmodule
